// File: rtl/wbn_pkg.sv
// Shared types for the Wishbone master engine.
//   status_t        : response status returned on rsp_sts
//   wbn_mst_state_t : master FSM state encoding
//   cnt_width()     : counter width for a 0..max_val range, never below 1 bit
package wbn_pkg;

   typedef enum logic [1:0] {WBN_OK, WBN_ERR, WBN_RTY, WBN_TMO} status_t;

   typedef enum logic [2:0] {StIdle, StReq, StWait, StBackoff, StRsp} wbn_mst_state_t;

   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val == 0) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wbn_tmo.sv
// Bus-phase timeout counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : restart the count from zero (new strobe phase)
//   en       : count this cycle (master is in REQ/WAIT)
//   expired  : this is the TMO-th counted cycle; never asserted when TMO = 0
module wbn_tmo
   import wbn_pkg::*;
#(
   parameter int unsigned TMO = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = cnt_width(TMO);
   // The first counted cycle sees 0, so the TMO-th sees TMO-1.
   localparam logic [CW-1:0] Last = CW'((TMO == 0) ? 0 : TMO - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (TMO != 0) && en && (cnt_q == Last);

endmodule

// File: rtl/wbn_master.sv
// Wishbone master engine: one request in, one single Wishbone transfer, one response out.
//   req_*   : request stream (valid/ready), write enable, address, byte select, write data
//   rsp_*   : response stream (valid/ready), read data, status_t
//   cyc stb we adr sel dat_w : Wishbone master outputs (all registered)
//   dat_r ack err rty stall  : Wishbone slave inputs (stall used in PIPELINED mode only)
// RTY is retried up to RTY_MAX times with a one-cycle idle gap; TMO bounds every strobe phase.
module wbn_master
   import wbn_pkg::*;
#(
   parameter string       MODE    = "CLASSIC",
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned SW      = DW / 8,
   parameter int unsigned RTY_MAX = 3,
   parameter int unsigned TMO     = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_vld,
   output logic          req_rdy,
   input  logic          req_wen,
   input  logic [AW-1:0] req_adr,
   input  logic [SW-1:0] req_sel,
   input  logic [DW-1:0] req_dtw,
   output logic          rsp_vld,
   input  logic          rsp_rdy,
   output logic [DW-1:0] rsp_dtr,
   output status_t       rsp_sts,
   output logic          cyc,
   output logic          stb,
   output logic          we,
   output logic [AW-1:0] adr,
   output logic [SW-1:0] sel,
   output logic [DW-1:0] dat_w,
   input  logic [DW-1:0] dat_r,
   input  logic          ack,
   input  logic          err,
   input  logic          rty,
   input  logic          stall
);

   if (MODE != "CLASSIC" && MODE != "PIPELINED") begin : g_bad_mode
      $error("wbn_master: MODE must be \"CLASSIC\" or \"PIPELINED\"");
   end
   if ((DW % 8) != 0 || SW != DW / 8) begin : g_bad_width
      $error("wbn_master: DW must be a multiple of 8 and SW = DW/8");
   end

   localparam bit          Pipe = (MODE == "PIPELINED");
   localparam int unsigned RW   = cnt_width(RTY_MAX);

   wbn_mst_state_t state_q, state_d;
   logic [RW-1:0]  rty_q, rty_d;
   logic           cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [AW-1:0]  adr_q, adr_d;
   logic [SW-1:0]  sel_q, sel_d;
   logic [DW-1:0]  dat_w_q, dat_w_d;
   logic           req_rdy_q, req_rdy_d, rsp_vld_q, rsp_vld_d;
   logic [DW-1:0]  rsp_dtr_q, rsp_dtr_d;
   status_t        rsp_sts_q, rsp_sts_d;

   logic           tmo_clr, tmo_en, tmo_exp;
   logic           sampled, done;
   status_t        done_sts;
   logic [DW-1:0]  done_dtr;

   wbn_tmo #(
      .TMO (TMO)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_exp)
   );

   // A pipelined slave holding stall has not accepted the strobe, so its terminations don't count.
   assign sampled = (state_q == StWait) || !Pipe || !stall;

   always_comb begin
      state_d   = state_q;
      rty_d     = rty_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      adr_d     = adr_q;
      sel_d     = sel_q;
      dat_w_d   = dat_w_q;
      req_rdy_d = req_rdy_q;
      rsp_vld_d = rsp_vld_q;
      rsp_dtr_d = rsp_dtr_q;
      rsp_sts_d = rsp_sts_q;
      tmo_clr   = 1'b0;
      tmo_en    = 1'b0;
      done      = 1'b0;
      done_sts  = WBN_OK;
      done_dtr  = '0;

      case (state_q)
         StIdle: begin
            if (req_vld) begin
               state_d   = StReq;
               cyc_d     = 1'b1;
               stb_d     = 1'b1;
               we_d      = req_wen;
               adr_d     = req_adr;
               sel_d     = req_sel;
               dat_w_d   = req_dtw;
               req_rdy_d = 1'b0;
               rty_d     = '0;
               tmo_clr   = 1'b1;
            end
         end
         StReq, StWait: begin
            tmo_en = 1'b1;
            // Priority err > rty > ack; a termination beats a same-cycle timeout.
            if (sampled && (ack || err || rty)) begin
               if (err) begin
                  done     = 1'b1;
                  done_sts = WBN_ERR;
               end else if (rty) begin
                  if (32'(rty_q) < RTY_MAX) begin
                     rty_d   = rty_q + RW'(1);
                     state_d = StBackoff;
                     cyc_d   = 1'b0;
                     stb_d   = 1'b0;
                  end else begin
                     done     = 1'b1;
                     done_sts = WBN_RTY;
                  end
               end else begin
                  done     = 1'b1;
                  done_sts = WBN_OK;
                  done_dtr = we_q ? '0 : dat_r;
               end
            end else if (tmo_exp) begin
               done     = 1'b1;
               done_sts = WBN_TMO;
            end else if (Pipe && state_q == StReq && !stall) begin
               state_d = StWait;
               stb_d   = 1'b0;
            end
            if (done) begin
               state_d   = StRsp;
               cyc_d     = 1'b0;
               stb_d     = 1'b0;
               rsp_vld_d = 1'b1;
               rsp_sts_d = done_sts;
               rsp_dtr_d = done_dtr;
            end
         end
         StBackoff: begin
            // Re-issue the latched transfer unchanged with a fresh timeout window.
            state_d = StReq;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            tmo_clr = 1'b1;
         end
         StRsp: begin
            if (rsp_rdy) begin
               state_d   = StIdle;
               rsp_vld_d = 1'b0;
               rsp_dtr_d = '0;
               rsp_sts_d = WBN_OK;
               req_rdy_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         rty_q     <= '0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         sel_q     <= '0;
         dat_w_q   <= '0;
         req_rdy_q <= 1'b1;
         rsp_vld_q <= 1'b0;
         rsp_dtr_q <= '0;
         rsp_sts_q <= WBN_OK;
      end else begin
         state_q   <= state_d;
         rty_q     <= rty_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         sel_q     <= sel_d;
         dat_w_q   <= dat_w_d;
         req_rdy_q <= req_rdy_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_dtr_q <= rsp_dtr_d;
         rsp_sts_q <= rsp_sts_d;
      end
   end

   assign req_rdy = req_rdy_q;
   assign rsp_vld = rsp_vld_q;
   assign rsp_dtr = rsp_dtr_q;
   assign rsp_sts = rsp_sts_q;
   assign cyc     = cyc_q;
   assign stb     = stb_q;
   assign we      = we_q;
   assign adr     = adr_q;
   assign sel     = sel_q;
   assign dat_w   = dat_w_q;

endmodule

// File: tb/tb_wbn_master.sv
// Bench for wbn_master: index 0 is a CLASSIC instance, index 1 a PIPELINED one,
// both with RTY_MAX=3 and TMO=8. Each transfer follows a per-phase slave plan
// (stall cycles, wait cycles, termination set); the expected outcome comes from model().
module tb_wbn_master;
   import wbn_pkg::*;

   localparam int TMO_T = 8;
   localparam int RMAX  = 3;
   localparam int K_ACK = 1;
   localparam int K_ERR = 2;
   localparam int K_RTY = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_vld [2];
   logic        req_rdy [2];
   logic        req_wen [2];
   logic [31:0] req_adr [2];
   logic [3:0]  req_sel [2];
   logic [31:0] req_dtw [2];
   logic        rsp_vld [2];
   logic        rsp_rdy [2];
   logic [31:0] rsp_dtr [2];
   status_t     rsp_sts [2];
   logic        cyc     [2];
   logic        stb     [2];
   logic        we      [2];
   logic [31:0] adr     [2];
   logic [3:0]  sel     [2];
   logic [31:0] dat_w   [2];
   logic [31:0] dat_r   [2];
   logic        ack     [2];
   logic        err     [2];
   logic        rty     [2];
   logic        stall   [2];

   wbn_master #(
      .MODE("CLASSIC"), .AW(32), .DW(32), .RTY_MAX(RMAX), .TMO(TMO_T)
   ) u_cls (
      .clk(clk), .rst(rst),
      .req_vld(req_vld[0]), .req_rdy(req_rdy[0]), .req_wen(req_wen[0]),
      .req_adr(req_adr[0]), .req_sel(req_sel[0]), .req_dtw(req_dtw[0]),
      .rsp_vld(rsp_vld[0]), .rsp_rdy(rsp_rdy[0]), .rsp_dtr(rsp_dtr[0]), .rsp_sts(rsp_sts[0]),
      .cyc(cyc[0]), .stb(stb[0]), .we(we[0]), .adr(adr[0]), .sel(sel[0]), .dat_w(dat_w[0]),
      .dat_r(dat_r[0]), .ack(ack[0]), .err(err[0]), .rty(rty[0]), .stall(stall[0])
   );

   wbn_master #(
      .MODE("PIPELINED"), .AW(32), .DW(32), .RTY_MAX(RMAX), .TMO(TMO_T)
   ) u_pip (
      .clk(clk), .rst(rst),
      .req_vld(req_vld[1]), .req_rdy(req_rdy[1]), .req_wen(req_wen[1]),
      .req_adr(req_adr[1]), .req_sel(req_sel[1]), .req_dtw(req_dtw[1]),
      .rsp_vld(rsp_vld[1]), .rsp_rdy(rsp_rdy[1]), .rsp_dtr(rsp_dtr[1]), .rsp_sts(rsp_sts[1]),
      .cyc(cyc[1]), .stb(stb[1]), .we(we[1]), .adr(adr[1]), .sel(sel[1]), .dat_w(dat_w[1]),
      .dat_r(dat_r[1]), .ack(ack[1]), .err(err[1]), .rty(rty[1]), .stall(stall[1])
   );

   int n_chk;
   int n_err;

   // Slave plan per strobe phase and the model's expectations.
   int          pl_s [4];
   int          pl_w [4];
   int          pl_k [4];
   int          exp_n;
   int          exp_cyc [4];
   int          exp_stb [4];
   status_t     exp_sts;
   logic [31:0] exp_dtr;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic set_plan(input int p, input int s, input int w, input int k);
      pl_s[p] = s;
      pl_w[p] = w;
      pl_k[p] = k;
   endtask

   task automatic rand_plan(input int d);
      int r;
      for (int p = 0; p < 4; p++) begin
         if (d == 1) pl_s[p] = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
         else        pl_s[p] = 0;
         pl_w[p] = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 9) : $urandom_range(0, 3);
         r = $urandom_range(0, 19);
         pl_k[p] = (r < 9)  ? K_ACK :
                   (r < 11) ? K_ERR :
                   (r < 16) ? K_RTY :
                   (r < 17) ? 0 :
                   (r < 18) ? (K_ACK | K_ERR) :
                   (r < 19) ? (K_ACK | K_RTY) : (K_ACK | K_ERR | K_RTY);
      end
   endtask

   // Outcome of a transfer from the plan: phase lengths, status and read data.
   task automatic model(input int d, input bit wen, input logic [31:0] rd);
      int  retries;
      int  t_term;
      int  p;
      bit  fin;
      retries = 0;
      fin     = 0;
      exp_n   = 0;
      exp_sts = WBN_OK;
      exp_dtr = '0;
      while (!fin) begin
         p      = exp_n;
         t_term = (d == 1) ? pl_s[p] + 1 + pl_w[p] : pl_w[p] + 1;
         if (pl_k[p] == 0 || t_term > TMO_T) begin
            exp_cyc[p] = TMO_T;
            exp_stb[p] = (d == 1) ? ((pl_s[p] + 1 < TMO_T) ? pl_s[p] + 1 : TMO_T) : TMO_T;
            exp_sts    = WBN_TMO;
            fin        = 1;
         end else begin
            exp_cyc[p] = t_term;
            exp_stb[p] = (d == 1) ? pl_s[p] + 1 : t_term;
            if ((pl_k[p] & K_ERR) != 0) begin
               exp_sts = WBN_ERR;
               fin     = 1;
            end else if ((pl_k[p] & K_RTY) != 0) begin
               if (retries < RMAX) retries++;
               else begin
                  exp_sts = WBN_RTY;
                  fin     = 1;
               end
            end else begin
               exp_sts = WBN_OK;
               exp_dtr = wen ? 32'h0 : rd;
               fin     = 1;
            end
         end
         exp_n++;
      end
   endtask

   task automatic quiet(input int d);
      ack[d]   = 1'b0;
      err[d]   = 1'b0;
      rty[d]   = 1'b0;
      stall[d] = 1'b0;
      dat_r[d] = '0;
   endtask

   // Terminations while no strobe phase is live must be ignored.
   task automatic drive_noise(input int d);
      ack[d]   = 1'($urandom_range(0, 1));
      err[d]   = 1'($urandom_range(0, 1));
      rty[d]   = 1'($urandom_range(0, 1));
      stall[d] = 1'($urandom_range(0, 1));
      dat_r[d] = $urandom;
   endtask

   // Slave response for cycle t (1-based) of strobe phase p.
   task automatic drive_bus(input int d, input int p, input int t, input logic [31:0] rd);
      bit hit;
      int k;
      quiet(d);
      dat_r[d] = $urandom;
      if (p > 3) return;
      k = pl_k[p];
      if (d == 1) begin
         if (t <= pl_s[p]) begin
            stall[d] = 1'b1;
            err[d]   = 1'($urandom_range(0, 1));
         end
         hit = (t == pl_s[p] + 1 + pl_w[p]);
      end else begin
         stall[d] = 1'($urandom_range(0, 1));
         hit = (t == pl_w[p] + 1);
      end
      if (hit) begin
         ack[d] = k[0];
         err[d] = k[1];
         rty[d] = k[2];
         if (k[0]) dat_r[d] = rd;
      end
   endtask

   task automatic issue(input int d, input bit a_wen, input logic [31:0] a_adr,
                        input logic [3:0] a_sel, input logic [31:0] a_dtw);
      chk("req_rdy", req_rdy[d], 1'b1);
      req_vld[d] = 1'b1;
      req_wen[d] = a_wen;
      req_adr[d] = a_adr;
      req_sel[d] = a_sel;
      req_dtw[d] = a_dtw;
      @(posedge clk); #1;
      req_vld[d] = 1'b0;
      req_wen[d] = 1'($urandom_range(0, 1));
      req_adr[d] = $urandom;
      req_sel[d] = 4'($urandom);
      req_dtw[d] = $urandom;
   endtask

   task automatic run_txn(input int d, input bit a_wen, input logic [31:0] a_adr,
                          input logic [3:0] a_sel, input logic [31:0] a_dtw,
                          input logic [31:0] rd, input int hold);
      int p, t, gap;
      bit in_ph, fin;
      int ocyc [4];
      int ostb [4];
      int ogap [4];
      model(d, a_wen, rd);
      for (int i = 0; i < 4; i++) begin
         ocyc[i] = 0;
         ostb[i] = 0;
         ogap[i] = 0;
      end
      p = 0; t = 0; gap = 0; in_ph = 0; fin = 0;
      rsp_rdy[d] = 1'b0;
      issue(d, a_wen, a_adr, a_sel, a_dtw);
      chk("stb_lat", {cyc[d], stb[d]}, 2'b11);
      for (int c = 0; c < 120 && !fin; c++) begin
         if (cyc[d]) begin
            if (!in_ph) begin
               in_ph = 1;
               t     = 0;
               if (p < 4) ogap[p] = gap;
               chk("bus_ctl", {we[d], sel[d], adr[d]}, {a_wen, a_sel, a_adr});
               chk("bus_dat", dat_w[d], a_dtw);
            end
            t++;
            if (p < 4) begin
               ocyc[p]++;
               if (stb[d]) ostb[p]++;
            end
            drive_bus(d, p, t, rd);
         end else begin
            if (in_ph) begin
               in_ph = 0;
               p++;
               gap = 0;
            end
            if (rsp_vld[d]) fin = 1;
            else begin
               gap++;
               drive_noise(d);
            end
         end
         if (!fin) begin
            @(posedge clk); #1;
         end
      end
      chk("budget", fin, 1'b1);
      chk("phases", p, exp_n);
      for (int i = 0; i < exp_n && i < 4; i++) begin
         chk("cyc_len", ocyc[i], exp_cyc[i]);
         chk("stb_len", ostb[i], exp_stb[i]);
         if (i > 0) chk("backoff", ogap[i], 1);
      end
      chk("rsp_lat", gap, 0);
      chk("sts", rsp_sts[d], exp_sts);
      chk("dtr", rsp_dtr[d], exp_dtr);
      for (int i = 0; i < hold; i++) begin
         drive_noise(d);
         @(posedge clk); #1;
         chk("hold", {rsp_vld[d], req_rdy[d], cyc[d], rsp_sts[d], rsp_dtr[d]},
             {1'b1, 1'b0, 1'b0, exp_sts, exp_dtr});
      end
      rsp_rdy[d] = 1'b1;
      @(posedge clk); #1;
      rsp_rdy[d] = 1'b0;
      chk("rsp_done", {rsp_vld[d], req_rdy[d], cyc[d]}, 3'b010);
      quiet(d);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "tb_wbn_master: simulation hung");
   end

   initial begin
      n_chk = 0;
      n_err = 0;
      for (int d = 0; d < 2; d++) begin
         req_vld[d] = 1'b0;
         req_wen[d] = 1'b0;
         req_adr[d] = '0;
         req_sel[d] = '0;
         req_dtw[d] = '0;
         rsp_rdy[d] = 1'b0;
         quiet(d);
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_ctl", {req_rdy[d], cyc[d], stb[d], we[d], rsp_vld[d], rsp_sts[d], sel[d]},
             {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, WBN_OK, 4'h0});
         chk("rst_adr", adr[d], 32'h0);
         chk("rst_dw", dat_w[d], 32'h0);
         chk("rst_dtr", rsp_dtr[d], 32'h0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Classic read, two wait states.
      set_plan(0, 0, 2, K_ACK);
      run_txn(0, 1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 0);

      // Pipelined write, three stall cycles, ack two cycles after acceptance.
      set_plan(0, 3, 2, K_ACK);
      run_txn(1, 1'b1, 32'h20, 4'h3, 32'hCAFEF00D, 32'h12345678, 0);

      // Three retries then ack; four retries exhaust the budget.
      for (int p = 0; p < 3; p++) set_plan(p, 0, 1, K_RTY);
      set_plan(3, 0, 0, K_ACK);
      run_txn(0, 1'b0, 32'h30, 4'hF, 32'h0, 32'h0A0B0C0D, 1);
      for (int p = 0; p < 4; p++) set_plan(p, 0, 0, K_RTY);
      run_txn(0, 1'b1, 32'h34, 4'h1, 32'h55AA55AA, 32'h0, 0);
      for (int p = 0; p < 3; p++) set_plan(p, 1, 0, K_RTY);
      set_plan(3, 1, 1, K_ACK);
      run_txn(1, 1'b0, 32'h38, 4'hF, 32'h0, 32'h600DF00D, 0);

      // Silent slave times out; ack in the expiry cycle wins.
      set_plan(0, 0, 0, 0);
      run_txn(0, 1'b0, 32'h50, 4'hF, 32'h0, 32'h11111111, 0);
      set_plan(0, 0, 7, K_ACK);
      run_txn(0, 1'b0, 32'h54, 4'hF, 32'h0, 32'h22222222, 0);
      set_plan(0, 2, 9, K_ACK);
      run_txn(1, 1'b0, 32'h58, 4'hF, 32'h0, 32'h33333333, 0);
      set_plan(0, 2, 5, K_ACK);
      run_txn(1, 1'b0, 32'h5C, 4'hF, 32'h0, 32'h44444444, 0);

      // ack and err together, response held off for five cycles.
      set_plan(0, 1, 1, K_ACK | K_ERR);
      run_txn(1, 1'b0, 32'h60, 4'hF, 32'h0, 32'h77777777, 5);

      // Reset while the pipelined master waits for a termination.
      quiet(1);
      issue(1, 1'b0, 32'h40, 4'hF, 32'h0);
      chk("t6_req", {cyc[1], stb[1]}, 2'b11);
      @(posedge clk); #1;
      chk("t6_wait", {cyc[1], stb[1]}, 2'b10);
      #2 rst = 1'b1;
      #1;
      chk("t6_async", {cyc[1], stb[1], rsp_vld[1], req_rdy[1]}, 4'b0001);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("t6_idle", {cyc[1], stb[1], rsp_vld[1], req_rdy[1]}, 4'b0001);
      set_plan(0, 0, 1, K_ACK);
      run_txn(1, 1'b0, 32'h44, 4'hF, 32'h0, 32'h0BADF00D, 0);

      // Randomised traffic on both instances.
      for (int i = 0; i < 40; i++) begin
         rand_plan(i % 2);
         run_txn(i % 2, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
                 $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
